// File: rtl/cordic_issue_scheduler.sv
// Round-robin, credit-gated issue of two requesters into a fixed-latency CORDIC pipeline.
// Results are tagged with the issuing requester and returned through a show-ahead FIFO.
module cordic_issue_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int FLIP_WIDTH   = 2,
    parameter int PIPE_LATENCY = 6,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_degree,
    input  logic [DATA_WIDTH-1:0] req0_x,
    input  logic [DATA_WIDTH-1:0] req0_y,
    input  logic [FLIP_WIDTH-1:0] req0_flip,
    input  logic                  req0_arctan_en,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_degree,
    input  logic [DATA_WIDTH-1:0] req1_x,
    input  logic [DATA_WIDTH-1:0] req1_y,
    input  logic [FLIP_WIDTH-1:0] req1_flip,
    input  logic                  req1_arctan_en,

    output logic                  pipe_valid_o,
    output logic [DATA_WIDTH-1:0] pipe_degree_o,
    output logic [DATA_WIDTH-1:0] pipe_x_o,
    output logic [DATA_WIDTH-1:0] pipe_y_o,
    output logic [FLIP_WIDTH-1:0] pipe_flip_o,
    output logic                  pipe_arctan_en_o,

    input  logic                  pipe_valid_i,
    input  logic [DATA_WIDTH-1:0] pipe_degree_i,
    input  logic [DATA_WIDTH-1:0] pipe_x_i,
    input  logic [DATA_WIDTH-1:0] pipe_y_i,
    input  logic [FLIP_WIDTH-1:0] pipe_flip_i,
    input  logic                  pipe_arctan_en_i,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_degree,
    output logic [DATA_WIDTH-1:0] rsp_x,
    output logic [DATA_WIDTH-1:0] rsp_y,
    output logic [FLIP_WIDTH-1:0] rsp_flip,
    output logic                  rsp_arctan_en,

    output logic [CNT_WIDTH-1:0]  credits_used,
    output logic                  err_sticky
);

    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int TAG_STAGES = PIPE_LATENCY + 1;

    typedef struct packed {
        logic                  id;
        logic [DATA_WIDTH-1:0] degree;
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic [FLIP_WIDTH-1:0] flip;
        logic                  arctan_en;
    } entry_t;

    // ---------------- arbitration and credit gating ----------------
    logic                 last_grant_reg;   // 1: requester 1 won the most recent accept
    logic [CNT_WIDTH-1:0] credits_reg;
    logic                 avail;
    logic                 grant0;
    logic                 grant1;
    logic                 accept0;
    logic                 accept1;
    logic                 accept;
    logic                 pop;

    assign avail   = credits_reg < CNT_WIDTH'(FIFO_DEPTH);
    // A requester is granted unless the other one is also valid and has priority.
    assign grant0  = !req1_valid || last_grant_reg;
    assign grant1  = !req0_valid || !last_grant_reg;
    assign req0_ready = !reset && avail && grant0;
    assign req1_ready = !reset && avail && grant1;
    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;
    assign accept  = accept0 || accept1;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
            credits_reg    <= '0;
        end else begin
            if (accept) begin
                last_grant_reg <= accept1;
            end
            credits_reg <= credits_reg + CNT_WIDTH'(accept) - CNT_WIDTH'(pop);
        end
    end

    // ---------------- pipeline issue registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_o     <= 1'b0;
            pipe_degree_o    <= '0;
            pipe_x_o         <= '0;
            pipe_y_o         <= '0;
            pipe_flip_o      <= '0;
            pipe_arctan_en_o <= 1'b0;
        end else begin
            pipe_valid_o <= accept;
            if (accept) begin
                pipe_degree_o    <= accept1 ? req1_degree    : req0_degree;
                pipe_x_o         <= accept1 ? req1_x         : req0_x;
                pipe_y_o         <= accept1 ? req1_y         : req0_y;
                pipe_flip_o      <= accept1 ? req1_flip      : req0_flip;
                pipe_arctan_en_o <= accept1 ? req1_arctan_en : req0_arctan_en;
            end
        end
    end

    // ---------------- requester tags, aligned with pipe_valid_i at the tail ----------------
    logic [TAG_STAGES-1:0] tag_valid_reg;
    logic [TAG_STAGES-1:0] tag_id_reg;
    logic                  tail_valid;
    logic                  tail_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            tag_valid_reg <= {tag_valid_reg[TAG_STAGES-2:0], accept};
            tag_id_reg    <= {tag_id_reg[TAG_STAGES-2:0], accept1};
        end
    end

    assign tail_valid = tag_valid_reg[TAG_STAGES-1];
    assign tail_id    = tag_id_reg[TAG_STAGES-1];

    // ---------------- result FIFO ----------------
    entry_t               mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_reg;
    logic [PTR_WIDTH-1:0] rd_ptr_reg;
    logic [PTR_WIDTH-1:0] rd_ptr_next;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 full;
    logic                 push_req;
    logic                 push;
    logic                 err_next;
    entry_t               push_data;
    entry_t               head_reg;
    entry_t               head_next;
    logic                 head_valid_reg;

    assign full     = count_reg == CNT_WIDTH'(FIFO_DEPTH);
    assign push_req = pipe_valid_i && tail_valid;
    assign pop      = head_valid_reg && rsp_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    assign push_data = '{id: tail_id, degree: pipe_degree_i, x: pipe_x_i, y: pipe_y_i,
                         flip: pipe_flip_i, arctan_en: pipe_arctan_en_i};

    always_comb begin
        rd_ptr_next = rd_ptr_reg + PTR_WIDTH'(pop);
        count_next  = count_reg + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        // The new head bypasses the array when it is being written this cycle.
        head_next   = (push && (rd_ptr_next == wr_ptr_reg)) ? push_data : mem[rd_ptr_next];
        err_next    = (pipe_valid_i && !tail_valid) ||
                      (tail_valid && !pipe_valid_i) ||
                      (push_req && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_reg       <= '0;
            head_valid_reg <= 1'b0;
            err_sticky     <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_reg + PTR_WIDTH'(push);
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            head_valid_reg <= count_next != '0;
            head_reg       <= (count_next != '0) ? head_next : '0;
            if (err_next) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign rsp_valid     = head_valid_reg;
    assign rsp_id        = head_reg.id;
    assign rsp_degree    = head_reg.degree;
    assign rsp_x         = head_reg.x;
    assign rsp_y         = head_reg.y;
    assign rsp_flip      = head_reg.flip;
    assign rsp_arctan_en = head_reg.arctan_en;
    assign credits_used  = credits_reg;

endmodule

// File: tb/tb_cordic_issue_scheduler.sv
// Randomized bench for cordic_issue_scheduler with an emulated 6-cycle pipeline and a
// transaction-level model: arbitration rule, credit count and an in-order result queue.
module tb_cordic_issue_scheduler;

    localparam int DW    = 16;
    localparam int FW    = 2;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req0_valid, req0_ready, req0_arctan_en;
    logic [DW-1:0] req0_degree, req0_x, req0_y;
    logic [FW-1:0] req0_flip;
    logic          req1_valid, req1_ready, req1_arctan_en;
    logic [DW-1:0] req1_degree, req1_x, req1_y;
    logic [FW-1:0] req1_flip;
    logic          pipe_valid_o, pipe_arctan_en_o;
    logic [DW-1:0] pipe_degree_o, pipe_x_o, pipe_y_o;
    logic [FW-1:0] pipe_flip_o;
    logic          pipe_valid_i, pipe_arctan_en_i;
    logic [DW-1:0] pipe_degree_i, pipe_x_i, pipe_y_i;
    logic [FW-1:0] pipe_flip_i;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_arctan_en;
    logic [DW-1:0] rsp_degree, rsp_x, rsp_y;
    logic [FW-1:0] rsp_flip;
    logic [CW-1:0] credits_used;
    logic          err_sticky;

    cordic_issue_scheduler dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_degree(req0_degree),
        .req0_x(req0_x), .req0_y(req0_y), .req0_flip(req0_flip), .req0_arctan_en(req0_arctan_en),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_degree(req1_degree),
        .req1_x(req1_x), .req1_y(req1_y), .req1_flip(req1_flip), .req1_arctan_en(req1_arctan_en),
        .pipe_valid_o(pipe_valid_o), .pipe_degree_o(pipe_degree_o), .pipe_x_o(pipe_x_o),
        .pipe_y_o(pipe_y_o), .pipe_flip_o(pipe_flip_o), .pipe_arctan_en_o(pipe_arctan_en_o),
        .pipe_valid_i(pipe_valid_i), .pipe_degree_i(pipe_degree_i), .pipe_x_i(pipe_x_i),
        .pipe_y_i(pipe_y_i), .pipe_flip_i(pipe_flip_i), .pipe_arctan_en_i(pipe_arctan_en_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_degree(rsp_degree),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_flip(rsp_flip), .rsp_arctan_en(rsp_arctan_en),
        .credits_used(credits_used), .err_sticky(err_sticky)
    );

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [FW-1:0] f;
        logic          a;
    } op_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] d;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [FW-1:0] f;
        logic          a;
        int            vis;
    } rsp_t;

    op_t  pq[$];       // emulated pipeline contents, one slot per cycle
    rsp_t exp_q[$];    // results owed to the consumer, in issue order
    op_t  exp_po;      // expected pipeline issue registers
    int   credits;
    logic last_id;
    logic e_err;
    int   cyc;
    int   p0, p1, pr;
    bit   inj;
    int   compared;
    int   mismatched;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit do_rst);
        op_t  cur, s, o;
        rsp_t r;
        logic e_r0, e_r1, e_rv, acc0, acc1, pop;
        @(negedge clk);
        reset          = do_rst;
        req0_valid     = ($urandom_range(99) < p0);
        req1_valid     = ($urandom_range(99) < p1);
        req0_degree    = DW'($urandom); req0_x = DW'($urandom); req0_y = DW'($urandom);
        req0_flip      = FW'($urandom); req0_arctan_en = 1'($urandom);
        req1_degree    = DW'($urandom); req1_x = DW'($urandom); req1_y = DW'($urandom);
        req1_flip      = FW'($urandom); req1_arctan_en = 1'($urandom);
        rsp_ready      = ($urandom_range(99) < pr);
        cur = {pipe_valid_o, pipe_degree_o, pipe_x_o, pipe_y_o, pipe_flip_o, pipe_arctan_en_o};
        if (pq.size() == LAT) s = pq.pop_front();
        else s = '0;
        // The emulated CORDIC applies a fixed, recognisable transform to each field.
        pipe_valid_i     = s.v | inj;
        pipe_degree_i    = s.d ^ 16'hA5C3;
        pipe_x_i         = s.x + 16'd3;
        pipe_y_i         = ~s.y;
        pipe_flip_i      = s.f;
        pipe_arctan_en_i = s.a;
        pq.push_back(cur);
        #1;

        // Both valid: the requester not granted last wins; a lone valid requester wins.
        e_r0 = !do_rst && (credits < DEPTH) && (!req1_valid || last_id);
        e_r1 = !do_rst && (credits < DEPTH) && (!req0_valid || !last_id);
        e_rv = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);

        check("req0_ready", 64'(req0_ready), 64'(e_r0));
        check("req1_ready", 64'(req1_ready), 64'(e_r1));
        check("pipe_valid_o", 64'(cur.v), 64'(exp_po.v));
        check("pipe_ops", 64'({cur.d, cur.x, cur.y, cur.f, cur.a}),
              64'({exp_po.d, exp_po.x, exp_po.y, exp_po.f, exp_po.a}));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        if (e_rv) begin
            check("rsp_data", 64'({rsp_id, rsp_degree, rsp_x, rsp_y, rsp_flip, rsp_arctan_en}),
                  64'({exp_q[0].id, exp_q[0].d, exp_q[0].x, exp_q[0].y, exp_q[0].f, exp_q[0].a}));
        end
        check("credits_used", 64'(credits_used), 64'(credits));
        check("err_sticky", 64'(err_sticky), 64'(e_err));

        acc0 = req0_valid && e_r0;
        acc1 = req1_valid && e_r1;
        pop  = e_rv && rsp_ready;
        if (do_rst) begin
            exp_q.delete();
            pq.delete();
            credits = 0;
            last_id = 1'b1;
            e_err   = 1'b0;
            exp_po  = '0;
        end else begin
            if (pop) begin
                r = exp_q.pop_front();
                $display("cyc=%0d pop id=%0d deg=%h x=%h y=%h flip=%0d atan=%0d",
                         cyc, r.id, r.d, r.x, r.y, r.f, r.a);
                credits--;
            end
            if (acc0 || acc1) begin
                if (acc1) o = {1'b1, req1_degree, req1_x, req1_y, req1_flip, req1_arctan_en};
                else      o = {1'b1, req0_degree, req0_x, req0_y, req0_flip, req0_arctan_en};
                r.id = acc1; r.d = o.d ^ 16'hA5C3; r.x = o.x + 16'd3; r.y = ~o.y;
                r.f = o.f; r.a = o.a; r.vis = cyc + LAT + 2;
                exp_q.push_back(r);
                credits++;
                last_id = acc1;
                exp_po  = o;
            end else begin
                exp_po.v = 1'b0;
            end
            if (inj) e_err = 1'b1;
        end
        cyc++;
    endtask

    task automatic run(input int n, input int a0, input int a1, input int ar);
        p0 = a0; p1 = a1; pr = ar;
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        compared = 0; mismatched = 0; cyc = 0;
        credits = 0; last_id = 1'b1; e_err = 1'b0; exp_po = '0; inj = 1'b0;
        p0 = 0; p1 = 0; pr = 100;
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_degree = '0; req0_x = '0; req0_y = '0; req0_flip = '0; req0_arctan_en = 1'b0;
        req1_valid = 1'b0; req1_degree = '0; req1_x = '0; req1_y = '0; req1_flip = '0; req1_arctan_en = 1'b0;
        pipe_valid_i = 1'b0; pipe_degree_i = '0; pipe_x_i = '0; pipe_y_i = '0;
        pipe_flip_i = '0; pipe_arctan_en_i = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1);
        run(6, 0, 0, 100);
        run(1, 100, 0, 100);            // single req0 op, then watch its latency
        run(12, 0, 0, 100);
        run(40, 100, 100, 100);         // both requesters contend continuously
        run(20, 0, 0, 100);
        run(30, 100, 0, 0);             // consumer stalled: credits run out
        run(1, 100, 0, 100);            // one pop frees one credit
        run(4, 100, 0, 0);
        run(40, 0, 100, 100);           // full FIFO with pop and accept together
        run(20, 0, 0, 100);
        inj = 1'b1;
        run(1, 0, 0, 100);              // stray pipeline result with nothing in flight
        inj = 1'b0;
        run(4, 0, 0, 100);
        step(1'b1);
        run(4, 100, 0, 100);            // reset with ops in flight
        step(1'b1);
        run(20, 0, 0, 100);
        for (int i = 0; i < 1500; i++) begin
            p0 = 50; p1 = 50; pr = 60;
            step($urandom_range(199) == 0);
        end
        run(20, 0, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
